// File: rtl/sync_filter.sv
// sync_filter: per-channel flop synchronizer, optional debounce filter, optional edge detector.
// Edge pulses are built only when SYNC_FILTER_EDGE_EN is defined; otherwise rise_o/fall_o are tied to 0.
module sync_filter #(
  parameter int                  CHANNELS    = 1,
  parameter int                  STAGES      = 2,
  parameter int                  FILTER      = 0,
  parameter logic [CHANNELS-1:0] RESET_VALUE = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [CHANNELS-1:0] serial_i,
  output logic [CHANNELS-1:0] serial_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] busy_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_filter: STAGES must be at least 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_filter: CHANNELS must be at least 1");
  end
  if (FILTER < 0) begin : g_bad_filter
    $error("sync_filter: FILTER must not be negative");
  end

  logic [CHANNELS-1:0] sync_r [STAGES];
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] level_s;

  // Synchronizer chain: flop-to-flop only, no logic between stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) sync_r[i] <= RESET_VALUE;
    end else if (clear_i) begin
      for (int i = 0; i < STAGES; i++) sync_r[i] <= RESET_VALUE;
    end else begin
      sync_r[0] <= serial_i;
      for (int i = 1; i < STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign sync_s = sync_r[STAGES-1];

  if (FILTER == 0) begin : g_no_filter
    assign level_s = sync_s;
    assign busy_o  = {CHANNELS{1'b0}};
  end else begin : g_filter
    localparam int            CW       = $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CW-1:0]       cnt_r [CHANNELS];
    logic [CHANNELS-1:0] out_r;
    logic [CHANNELS-1:0] busy_s;

    // Debounce: a new synced value must persist FILTER cycles before it is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_r <= RESET_VALUE;
        for (int c = 0; c < CHANNELS; c++) cnt_r[c] <= {CW{1'b0}};
      end else if (clear_i) begin
        out_r <= RESET_VALUE;
        for (int c = 0; c < CHANNELS; c++) cnt_r[c] <= {CW{1'b0}};
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (sync_s[c] == out_r[c]) begin
            cnt_r[c] <= {CW{1'b0}};
          end else if (cnt_r[c] == CNT_LAST) begin
            out_r[c] <= sync_s[c];
            cnt_r[c] <= {CW{1'b0}};
          end else begin
            cnt_r[c] <= cnt_r[c] + CW'(1);
          end
        end
      end
    end

    // Pending-change flag per channel.
    always_comb begin
      busy_s = {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        if (cnt_r[c] != {CW{1'b0}}) begin
          busy_s[c] = 1'b1;
        end else begin
          busy_s[c] = 1'b0;
        end
      end
    end

    assign level_s = out_r;
    assign busy_o  = busy_s;
  end

`ifdef SYNC_FILTER_EDGE_EN
  logic [CHANNELS-1:0] prev_r;

  // Previous output level; pulses are suppressed while clear_i is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_r <= RESET_VALUE;
    end else if (clear_i) begin
      prev_r <= RESET_VALUE;
    end else begin
      prev_r <= level_s;
    end
  end

  assign rise_o =  level_s & ~prev_r & ~{CHANNELS{clear_i}};
  assign fall_o = ~level_s &  prev_r & ~{CHANNELS{clear_i}};
`else
  assign rise_o = {CHANNELS{1'b0}};
  assign fall_o = {CHANNELS{1'b0}};
`endif

  assign serial_o = level_s;

endmodule
